// File: rtl/edac_pkg.sv
// Shared definitions for the EDAC scrubber.
// Holds the default geometry of the protected memory, the scrubber FSM
// state encoding and the SEC-DED error classification.
package edac_pkg;

  localparam int EDAC_DATA_BITS      = 128;
  localparam int EDAC_PARITY_BITS    = 9;
  localparam int EDAC_ADDR_BITS      = 10;
  localparam int EDAC_MEM_DEPTH      = 1024;
  localparam int EDAC_SCRUB_INTERVAL = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    CHECK   = 3'd4,
    WR_REQ  = 3'd5,
    NEXT    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } err_class_e;

endpackage

// File: rtl/edac_secded_check.sv
// Combinational extended-Hamming SEC-DED checker.
// Codeword bit p holds position p (1-based). Positions 1..N-1 form a plain
// Hamming code (check bits at powers of two); position N is even parity over
// the whole word.
//   codeword  : stored codeword, positions [N:1]
//   corrected : codeword with a single-bit error repaired (else unchanged)
//   syndrome  : XOR of the indices of set bits in positions 1..N-1
//   err_class : CLEAN, CORR or UNCORR
module edac_secded_check
  import edac_pkg::*;
#(
  parameter int DATA_BITS   = EDAC_DATA_BITS,
  parameter int PARITY_BITS = EDAC_PARITY_BITS
) (
  input  logic [DATA_BITS+PARITY_BITS:1] codeword,
  output logic [DATA_BITS+PARITY_BITS:1] corrected,
  output logic [PARITY_BITS-2:0]         syndrome,
  output err_class_e                     err_class
);

  localparam int N  = DATA_BITS + PARITY_BITS;
  localparam int SW = PARITY_BITS - 1;

  logic parity;

  always_comb begin
    syndrome = '0;
    for (int p = 1; p < N; p++) begin
      if (codeword[p]) syndrome = syndrome ^ SW'(p);
    end
  end

  assign parity = ^codeword;

  always_comb begin
    err_class = CLEAN;
    corrected = codeword;
    if (parity) begin
      if (syndrome == '0) begin
        // Only the overall parity bit itself is wrong.
        err_class    = CORR;
        corrected[N] = ~codeword[N];
      end else if (int'(syndrome) < N) begin
        err_class = CORR;
        for (int p = 1; p < N; p++) begin
          if (syndrome == SW'(p)) corrected[p] = ~codeword[p];
        end
      end else begin
        // Odd parity but the syndrome points past the word: not a single error.
        err_class = UNCORR;
      end
    end else if (syndrome != '0) begin
      err_class = UNCORR;
    end
  end

endmodule

// File: rtl/edac_scrubber.sv
// Background memory scrubber with SEC-DED correction and write-back.
// Sweeps addresses 0..MEM_DEPTH-1, idling SCRUB_INTERVAL cycles before each
// read, writes back corrected codewords and counts errors.
//   clk, reset         : clock, asynchronous active-high reset
//   scrub_en           : enable sweeping
//   clear_cnt          : zero both error counters (wins over increments)
//   mem_req/we/addr/wdata, mem_gnt : request channel; a request is held
//                        stable until mem_gnt is seen high with it
//   mem_rvalid/rdata   : read return; only sampled in RD_WAIT
//   busy               : FSM not in IDLE
//   corr_cnt, uncorr_cnt, last_err_addr : saturating error statistics
//   uncorr_irq, sweep_done : one-cycle pulses
// Handshake: a transfer happens on a rising clk edge where mem_req and
// mem_gnt are both 1; only one transaction is ever outstanding.
module edac_scrubber
  import edac_pkg::*;
#(
  parameter int DATA_BITS      = EDAC_DATA_BITS,
  parameter int PARITY_BITS    = EDAC_PARITY_BITS,
  parameter int ADDR_BITS      = EDAC_ADDR_BITS,
  parameter int MEM_DEPTH      = EDAC_MEM_DEPTH,
  parameter int SCRUB_INTERVAL = EDAC_SCRUB_INTERVAL
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           scrub_en,
  input  logic                           clear_cnt,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS+PARITY_BITS:1] mem_wdata,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  input  logic [DATA_BITS+PARITY_BITS:1] mem_rdata,
  output logic                           busy,
  output logic [15:0]                    corr_cnt,
  output logic [15:0]                    uncorr_cnt,
  output logic [ADDR_BITS-1:0]           last_err_addr,
  output logic                           uncorr_irq,
  output logic                           sweep_done
);

  localparam int N  = DATA_BITS + PARITY_BITS;
  localparam int CW = $clog2(SCRUB_INTERVAL) + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_DEPTH - 1);

  state_e                 state;
  logic [CW-1:0]          wait_cnt;
  logic [N:1]             rdata_q;
  logic [N:1]             fixed;
  logic [PARITY_BITS-2:0] syndrome;
  err_class_e             cls;
  logic                   unused_syndrome;

  edac_secded_check #(
    .DATA_BITS  (DATA_BITS),
    .PARITY_BITS(PARITY_BITS)
  ) u_check (
    .codeword (rdata_q),
    .corrected(fixed),
    .syndrome (syndrome),
    .err_class(cls)
  );

  assign unused_syndrome = ^syndrome;
  assign busy            = (state != IDLE);

  // mem_addr doubles as the sweep pointer; it only changes in NEXT, so it is
  // stable for the whole life of a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rdata_q       <= '0;
      corr_cnt      <= '0;
      uncorr_cnt    <= '0;
      last_err_addr <= '0;
      uncorr_irq    <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      uncorr_irq <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (scrub_en) begin
            state    <= WAIT;
            wait_cnt <= CW'(SCRUB_INTERVAL - 1);
          end
        end
        WAIT: begin
          if (!scrub_en) begin
            state <= IDLE;
          end else if (wait_cnt == '0) begin
            state   <= RD_REQ;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RD_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state   <= CHECK;
          end
        end
        CHECK: begin
          case (cls)
            CORR: begin
              mem_wdata <= fixed;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              state     <= WR_REQ;
              if (corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
            end
            UNCORR: begin
              if (uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
              last_err_addr <= mem_addr;
              uncorr_irq    <= 1'b1;
              sweep_done    <= (mem_addr == LAST_ADDR);
              state         <= NEXT;
            end
            default: begin
              sweep_done <= (mem_addr == LAST_ADDR);
              state      <= NEXT;
            end
          endcase
        end
        WR_REQ: begin
          if (mem_gnt) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            sweep_done <= (mem_addr == LAST_ADDR);
            state      <= NEXT;
          end
        end
        NEXT: begin
          // sweep_done was raised on entry so it is visible during NEXT.
          mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
          if (scrub_en) begin
            state    <= WAIT;
            wait_cnt <= CW'(SCRUB_INTERVAL - 1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a clear overrides a same-cycle increment.
      if (clear_cnt) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/edac_scrubber.md
EDAC_SCRUBBER -- requirements
Module: edac_scrubber

Interface
REQ-001 Parameters SHALL be:
- DATA_BITS, default 128, data width k.
- PARITY_BITS, default 9, check width r.
- ADDR_BITS, default 10, memory address width.
- MEM_DEPTH, default 1024, number of codewords swept.
- SCRUB_INTERVAL, default 256, idle cycles before each read (minimum 1).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- scrub_en, in, 1, enable sweeping.
- clear_cnt, in, 1, zero both error counters.
- mem_req, out, 1, memory request.
- mem_we, out, 1, 1 = write, 0 = read.
- mem_addr, out, ADDR_BITS, request address.
- mem_wdata, out, k+r, corrected codeword, bits [k+r:1].
- mem_gnt, in, 1, request accepted this cycle.
- mem_rvalid, in, 1, read data valid.
- mem_rdata, in, k+r, stored codeword.
- busy, out, 1, FSM not in IDLE.
- corr_cnt, out, 16, corrected-error count.
- uncorr_cnt, out, 16, uncorrectable-error count.
- last_err_addr, out, ADDR_BITS, address of latest uncorrectable error.
- uncorr_irq, out, 1, one-cycle pulse.
- sweep_done, out, 1, one-cycle pulse.
REQ-003 Clock and reset SHALL be exactly one clock (clk) with asynchronous, active-high reset (reset).

Function
REQ-004 Code SHALL be extended Hamming SEC-DED over positions 1..k+r:
- Hamming check bits at positions 2^i, i=0..7.
- Data bit j at the j-th non-power-of-two position, ascending (data bit 1 at position 3).
- Position 137 = even parity over positions 1..136.
REQ-005 Check SHALL compute syndrome S = XOR of indices of set bits in positions 1..136, and P = XOR of all 137 bits.
REQ-006 Classification SHALL be:
- S=0, P=0: clean.
- P=1 with S=0: single error on bit 137.
- P=1 with S in 1..136: single error on position S.
- P=1 with S>136: uncorrectable.
- S!=0, P=0: uncorrectable.
REQ-007 FSM states SHALL be IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
REQ-008 IDLE SHALL go to WAIT when scrub_en=1, loading the interval counter with SCRUB_INTERVAL-1.
REQ-009 WAIT SHALL decrement each cycle and go to RD_REQ on the cycle the counter is 0.
REQ-010 RD_REQ SHALL drive mem_req=1, mem_we=0, mem_addr=current address; all held stable until mem_gnt, then go to RD_WAIT.
REQ-011 RD_WAIT SHALL register mem_rdata on mem_rvalid and go to CHECK; mem_rvalid in any other state SHALL be ignored.
REQ-012 CHECK SHALL last exactly one cycle, then:
- clean: go to NEXT.
- correctable: register the corrected codeword, increment corr_cnt, go to WR_REQ.
- uncorrectable: increment uncorr_cnt, load last_err_addr, pulse uncorr_irq, go to NEXT; no write.
REQ-013 WR_REQ SHALL drive mem_req=1, mem_we=1, and the corrected codeword on mem_wdata, held until mem_gnt, then go to NEXT.
REQ-014 NEXT SHALL advance the address:
- increment, wrapping MEM_DEPTH-1 to 0.
- on the wrap, pulse sweep_done.
- go to WAIT if scrub_en=1, else IDLE.
REQ-015 Deasserting scrub_en outside IDLE/WAIT SHALL NOT abort the current address; it completes through NEXT, then IDLE. Deasserting it in WAIT SHALL return to IDLE immediately with the address unchanged.
REQ-016 Counters SHALL saturate at 16'hFFFF.
REQ-017 clear_cnt SHALL zero both counters next cycle and win over a simultaneous increment.
REQ-018 mem_req SHALL be 0 in all states except RD_REQ and WR_REQ.
REQ-019 Throughput SHALL be at most one outstanding memory transaction.

Reset
REQ-020 On reset, all outputs SHALL be 0:
- mem_req, mem_we, mem_addr, mem_wdata, busy, counters, last_err_addr, uncorr_irq, sweep_done.
- State SHALL go to IDLE and the current address to 0.
REQ-021 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously); no pending write survives.

Structure
REQ-022 Package edac_pkg SHALL hold default widths, the FSM state encoding, and the error-class encoding (CLEAN, CORR, UNCORR).
REQ-023 Sub-module edac_secded_check (combinational: codeword in; corrected codeword, S, class out) SHALL implement REQ-004 to REQ-006.

Verification (MEM_DEPTH=4, SCRUB_INTERVAL=2, gnt same cycle, rvalid 2 cycles after gnt)
REQ-024 All-zero memory, scrub_en=1 -> reads at addresses 0,1,2,3, no writes, sweep_done one cycle after the address-3 CHECK, counters 0.
REQ-025 Address 2 with data bit 1 (position 3) flipped -> one write to address 2 with the all-zero codeword, corr_cnt=1.
REQ-026 Address 1 with positions 3 and 5 flipped -> no write, uncorr_cnt=1, last_err_addr=1, uncorr_irq high for exactly one cycle.
REQ-027 Only bit 137 flipped at address 0 -> write-back of the all-zero codeword, corr_cnt=1.
REQ-028 mem_gnt withheld 5 cycles during RD_REQ -> mem_req/mem_addr stable throughout; scrub_en dropped in RD_WAIT -> CHECK completes, then IDLE, busy=0.
REQ-029 reset pulsed during WR_REQ -> mem_req=0 immediately, all outputs 0, next sweep starts at address 0; clear_cnt with a simultaneous correction -> corr_cnt=0.
